// File: rtl/pipe_pkg.sv
// Shared sizing helpers for the elastic buffer: pointer/count widths and the
// power-of-two depth check used at elaboration.
package pipe_pkg;

  // Index bits only; the pointer register carries one extra wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  // Occupancy 0..DEPTH needs one bit more than the index.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/pipe_elastic_ptr.sv
// Wrap-bit pointer for the elastic buffer. DEPTH is a power of two, so a plain
// binary increment wraps the index and toggles the top (wrap) bit for free.
module pipe_elastic_ptr
  import pipe_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = ptr_width(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        inc,
  output logic [PW:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (inc) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_elastic.sv
// DEPTH-entry show-ahead elastic buffer with registered o_want, occupancy and
// almost-full. Define PIPE_ELASTIC_BYPASS_EN for zero-latency fall-through when empty.
module pipe_elastic
  import pipe_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = DEPTH - 1,
  localparam int CW = count_width(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [WIDTH-1:0] i_in,
  input  logic             i_have,
  output logic             o_want,
  output logic [WIDTH-1:0] o_out,
  output logic             o_have,
  input  logic             i_want,
  input  logic             i_flush,
  output logic [CW-1:0]    o_count,
  output logic             o_almost_full
);

  localparam int PW = ptr_width(DEPTH);

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("pipe_elastic: DEPTH must be a power of two >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_thresh
    $error("pipe_elastic: AF_THRESH must be in 1..DEPTH");
  end

  // Handshake: a beat moves on an edge only when its have and want are both
  // high; have without want is a stall and the beat must be held stable.

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]    count_q, count_next;
  logic             want_q, af_q;
  logic             empty, fall_through;
  logic             push, pop, wr_en, rd_en;

  assign empty = (wr_ptr == rd_ptr);

`ifdef PIPE_ELASTIC_BYPASS_EN
  assign fall_through = empty && i_have && want_q && !i_flush;
`else
  assign fall_through = 1'b0;
`endif

  assign o_have = !empty || fall_through;
  assign o_out  = fall_through ? i_in : mem[rd_ptr[PW-1:0]];
  assign o_want = want_q;
  assign o_count = count_q;
  assign o_almost_full = af_q;

  assign push = i_have && want_q;
  assign pop  = o_have && i_want;
  // A fall-through beat consumed the same cycle never touches storage.
  assign wr_en = push && !(fall_through && i_want) && !i_flush;
  assign rd_en = pop && !empty && !i_flush;

  always_comb begin
    count_next = count_q;
    if (i_flush) begin
      count_next = '0;
    end else begin
      count_next = count_q + CW'(wr_en) - CW'(rd_en);
    end
  end

  pipe_elastic_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .clear (i_flush),
    .inc   (wr_en),
    .value (wr_ptr)
  );

  pipe_elastic_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .clear (i_flush),
    .inc   (rd_en),
    .value (rd_ptr)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count_q <= '0;
      want_q  <= 1'b0;
      af_q    <= 1'b0;
    end else begin
      count_q <= count_next;
      want_q  <= (count_next < CW'(DEPTH));
      af_q    <= (count_next >= CW'(AF_THRESH));
    end
  end

  // Storage is deliberately left unreset; only the pointers define validity.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wr_ptr[PW-1:0]] <= i_in;
    end
  end

endmodule

// File: tb/tb_pipe_elastic.sv
// Self-checking bench for pipe_elastic (WIDTH=8, DEPTH=4) with a scoreboard queue;
// the fall-through scenario follows PIPE_ELASTIC_BYPASS_EN.
module tb_pipe_elastic;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] i_in;
  logic             i_have, i_want, i_flush;
  logic [WIDTH-1:0] o_out;
  logic             o_have, o_want, o_almost_full;
  logic [CW-1:0]    o_count;

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_v;

  pipe_elastic #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_in          (i_in),
    .i_have        (i_have),
    .o_want        (o_want),
    .o_out         (o_out),
    .o_have        (o_have),
    .i_want        (i_want),
    .i_flush       (i_flush),
    .o_count       (o_count),
    .o_almost_full (o_almost_full)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_in = '0; i_have = 1'b0; i_want = 1'b0; i_flush = 1'b0;
    step(); step();
    total++; if (o_have !== 1'b0) begin bad++; $display("FAIL reset_have: got %b want 0", o_have); end
    total++; if (o_want !== 1'b0) begin bad++; $display("FAIL reset_want: got %b want 0", o_want); end
    total++; if (o_count !== '0) begin bad++; $display("FAIL reset_count: got %0d want 0", o_count); end
    total++; if (o_almost_full !== 1'b0) begin bad++; $display("FAIL reset_af: got %b want 0", o_almost_full); end
    rst_n = 1'b1;
    step();
    total++; if (o_want !== 1'b1) begin bad++; $display("FAIL reset_release_want: got %b want 1", o_want); end
  endtask

  task automatic test_fill();
    i_want = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      i_in = WIDTH'(8'h11 * (i + 1));
      i_have = 1'b1;
      exp_q.push_back(i_in);
      step();
      total++; if (o_count !== CW'(i + 1)) begin bad++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, o_count, i + 1); end
      total++; if (o_almost_full !== ((i + 1) >= DEPTH - 1)) begin bad++; $display("FAIL fill_af[%0d]: got %b want %b", i, o_almost_full, (i + 1) >= DEPTH - 1); end
      total++; if (o_want !== ((i + 1) < DEPTH)) begin bad++; $display("FAIL fill_want[%0d]: got %b want %b", i, o_want, (i + 1) < DEPTH); end
    end
    i_in = 8'h55;
    step();
    total++; if (o_count !== CW'(DEPTH)) begin bad++; $display("FAIL fill_fifth_count: got %0d want %0d", o_count, DEPTH); end
    total++; if (o_want !== 1'b0) begin bad++; $display("FAIL fill_fifth_want: got %b want 0", o_want); end
    total++; if (o_out !== 8'h11) begin bad++; $display("FAIL fill_head: got %h want 11", o_out); end
    i_have = 1'b0;
  endtask

  task automatic test_drain();
    i_have = 1'b0;
    i_want = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      settle();
      exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      total++; if (o_have !== 1'b1) begin bad++; $display("FAIL drain_have[%0d]: got %b want 1", i, o_have); end
      total++; if (o_out !== exp_v) begin bad++; $display("FAIL drain_data[%0d]: got %h want %h", i, o_out, exp_v); end
      step();
      if (i == 0) begin
        total++; if (o_want !== 1'b1) begin bad++; $display("FAIL drain_want_rise: got %b want 1", o_want); end
        total++; if (o_count !== CW'(DEPTH - 1)) begin bad++; $display("FAIL drain_count: got %0d want %0d", o_count, DEPTH - 1); end
      end
    end
    i_want = 1'b0;
    settle();
    total++; if (o_have !== 1'b0) begin bad++; $display("FAIL drain_empty_have: got %b want 0", o_have); end
    total++; if (o_count !== '0) begin bad++; $display("FAIL drain_empty_count: got %0d want 0", o_count); end
  endtask

  task automatic test_wrap();
    i_want = 1'b0;
    for (int i = 0; i < 2; i++) begin
      i_in = WIDTH'(8'hA0 + i);
      i_have = 1'b1;
      exp_q.push_back(i_in);
      step();
    end
    i_want = 1'b1;
    for (int i = 0; i < 10; i++) begin
      i_in = WIDTH'(i);
      settle();
      exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      total++; if (o_out !== exp_v) begin bad++; $display("FAIL wrap_data[%0d]: got %h want %h", i, o_out, exp_v); end
      exp_q.push_back(i_in);
      step();
      total++; if (o_count !== CW'(2)) begin bad++; $display("FAIL wrap_count[%0d]: got %0d want 2", i, o_count); end
    end
    i_have = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      total++; if (o_out !== exp_v) begin bad++; $display("FAIL wrap_tail[%0d]: got %h want %h", i, o_out, exp_v); end
      step();
    end
    i_want = 1'b0;
    settle();
    total++; if (o_count !== '0) begin bad++; $display("FAIL wrap_final_count: got %0d want 0", o_count); end
  endtask

  task automatic test_flush();
    i_want = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_in = WIDTH'(8'h31 + i);
      i_have = 1'b1;
      exp_q.push_back(i_in);
      step();
    end
    total++; if (o_count !== CW'(3)) begin bad++; $display("FAIL flush_pre_count: got %0d want 3", o_count); end
    i_in = 8'h77; i_have = 1'b1; i_want = 1'b1; i_flush = 1'b1;
    step();
    exp_q.delete();
    i_have = 1'b0; i_want = 1'b0; i_flush = 1'b0;
    settle();
    total++; if (o_count !== '0) begin bad++; $display("FAIL flush_count: got %0d want 0", o_count); end
    total++; if (o_have !== 1'b0) begin bad++; $display("FAIL flush_have: got %b want 0", o_have); end
    total++; if (o_want !== 1'b1) begin bad++; $display("FAIL flush_want: got %b want 1", o_want); end
    total++; if (o_almost_full !== 1'b0) begin bad++; $display("FAIL flush_af: got %b want 0", o_almost_full); end
    step();
    total++; if (o_have !== 1'b0) begin bad++; $display("FAIL flush_beat_absent: got %b want 0", o_have); end
  endtask

  task automatic test_async_reset();
    i_want = 1'b0;
    for (int i = 0; i < 2; i++) begin
      i_in = WIDTH'(8'h61 + i);
      i_have = 1'b1;
      exp_q.push_back(i_in);
      step();
    end
    total++; if (o_count !== CW'(2)) begin bad++; $display("FAIL areset_pre_count: got %0d want 2", o_count); end
    i_in = 8'h63;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (o_have !== 1'b0) begin bad++; $display("FAIL areset_have: got %b want 0", o_have); end
    total++; if (o_want !== 1'b0) begin bad++; $display("FAIL areset_want: got %b want 0", o_want); end
    total++; if (o_count !== '0) begin bad++; $display("FAIL areset_count: got %0d want 0", o_count); end
    total++; if (o_almost_full !== 1'b0) begin bad++; $display("FAIL areset_af: got %b want 0", o_almost_full); end
    i_have = 1'b0;
    exp_q.delete();
    step(); step();
    rst_n = 1'b1;
    step();
    total++; if (o_want !== 1'b1) begin bad++; $display("FAIL areset_release_want: got %b want 1", o_want); end
    total++; if (o_count !== '0) begin bad++; $display("FAIL areset_release_count: got %0d want 0", o_count); end
  endtask

  task automatic test_latency();
    i_in = 8'hA5; i_have = 1'b1; i_want = 1'b1;
    settle();
`ifdef PIPE_ELASTIC_BYPASS_EN
    total++; if (o_have !== 1'b1) begin bad++; $display("FAIL bypass_have: got %b want 1", o_have); end
    total++; if (o_out !== 8'hA5) begin bad++; $display("FAIL bypass_data: got %h want a5", o_out); end
    step();
    i_have = 1'b0;
    settle();
    total++; if (o_count !== '0) begin bad++; $display("FAIL bypass_count: got %0d want 0", o_count); end
    total++; if (o_have !== 1'b0) begin bad++; $display("FAIL bypass_after_have: got %b want 0", o_have); end
`else
    total++; if (o_have !== 1'b0) begin bad++; $display("FAIL latency_same_cycle_have: got %b want 0", o_have); end
    exp_q.push_back(i_in);
    step();
    i_have = 1'b0;
    settle();
    exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    total++; if (o_have !== 1'b1) begin bad++; $display("FAIL latency_have: got %b want 1", o_have); end
    total++; if (o_out !== exp_v) begin bad++; $display("FAIL latency_data: got %h want %h", o_out, exp_v); end
    total++; if (o_count !== CW'(1)) begin bad++; $display("FAIL latency_count: got %0d want 1", o_count); end
    step();
    total++; if (o_count !== '0) begin bad++; $display("FAIL latency_drained: got %0d want 0", o_count); end
`endif
    i_want = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_flush();
    test_async_reset();
    test_latency();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_elastic.md
# pipe_elastic

Parametrised elastic buffer for have/want streaming links: a DEPTH-entry register FIFO with show-ahead output, occupancy and almost-full reporting, synchronous flush, and optional zero-latency fall-through. It replaces the single-entry interlock stage where a link needs more than one beat of slack, for example across long routes between LU pipeline stages or ahead of variable-latency consumers.

## Interface
- WIDTH, default 32: data width in bits, ≥1.
- DEPTH, default 4: entry count; power of two, ≥2.
- AF_THRESH, default DEPTH-1: o_almost_full asserts when occupancy ≥ AF_THRESH; legal range 1..DEPTH.
- i_clk  in  1: single clock; all state updates on the rising edge.
- i_reset_n  in  1: asynchronous, active-low reset.
- i_in  in  WIDTH: upstream data.
- i_have  in  1: upstream beat valid.
- o_want  out  1: buffer can accept a beat.
- o_out  out  WIDTH: head-of-queue data.
- o_have  out  1: head beat valid.
- i_want  in  1: downstream accepts head.
- i_flush  in  1: synchronous clear of all entries.
- o_count  out  $clog2(DEPTH+1): current occupancy.
- o_almost_full  out  1: occupancy ≥ AF_THRESH.

## Operation
- Push = i_have && o_want. Pop = o_have && i_want. A beat transfers only when both sides of its handshake are high. i_have while o_want=0 is a stall, not an error.
- Storage: DEPTH × WIDTH register array, write pointer and read pointer each $clog2(DEPTH) bits plus a wrap bit. Full when indices are equal and wrap bits differ. Empty when both indices and wrap bits are equal.
- Pointers advance modulo DEPTH. The wrap bit toggles when an index goes from DEPTH-1 to 0.
- o_count = wr − rd, computed in $clog2(DEPTH)+1 bits and registered alongside the pointers. It is never derived from i_want combinationally.
- o_want is a register: next value = (count_next < DEPTH). There is no combinational path from i_want to o_want. When full, a simultaneous pop does not admit a push that cycle.
- o_have = (o_count ≠ 0). o_out = mem[rd index], show-ahead.
- o_almost_full = (o_count ≥ AF_THRESH), registered from count_next.
- Simultaneous push and pop when non-empty and non-full: both pointers advance and the count is unchanged.
- i_flush: on the next edge, pointers and count go to 0, o_want goes to 1, and o_almost_full goes to 0. A push or pop in the same cycle as the flush is discarded. The flush has priority over all other updates.
- Reset (i_reset_n low, at any time including mid-transfer): pointers 0, count 0, o_have 0, o_want 0, o_almost_full 0, o_count 0. o_out is undefined. Array contents are not reset.
- After reset releases, o_want rises on the first rising edge.

## Timing
- Without bypass: write-to-read latency is 1 cycle. A beat pushed at edge N is visible on o_out/o_have after edge N.
- Sustained throughput is 1 beat per cycle whenever the buffer is neither full nor empty.
- After the buffer fills, o_want falls at the edge that makes count = DEPTH. It rises at the edge following the first pop.
- o_count and o_almost_full change at the same edge as the pointers.

## Configuration
- Macro PIPE_ELASTIC_BYPASS_EN.
- Defined: when count = 0 and i_have = 1, o_have = 1 and o_out = i_in combinationally.
  - If i_want = 1 in that cycle, the beat passes with 0 latency and is not written, so the count stays 0.
  - If i_want = 0, the beat is written normally.
  - This creates combinational paths i_have→o_have and i_in→o_out. It adds no path to o_want.
  - During i_flush, the bypass path is inactive and o_have = 0.
- Undefined: there is no fall-through path and latency is exactly 1 cycle.

## Structure
- Shared package pipe_pkg: function for pointer width, function for count width, localparam check that DEPTH is a power of two (elaboration error otherwise).
- Sub-module pipe_elastic_ptr: a $clog2(DEPTH)+1-bit pointer with increment enable, synchronous clear (flush), and async active-low reset. It is instantiated twice, once for write and once for read.

## Test plan
- Reset then fill, WIDTH=8, DEPTH=4, i_want=0: push 0x11, 0x22, 0x33, 0x44 on consecutive cycles. Required: o_count steps 1..4, o_almost_full high at count 3, o_want low after the 4th edge, and a fifth i_have is not accepted.
- Drain from full, i_want=1, i_have=0: o_out reads 0x11, 0x22, 0x33, 0x44 in order. o_want returns high one edge after the first pop, and o_have is low after 4 pops.
- Wrap-around: 10 streaming beats 0x00..0x09 with i_have=i_want=1 after 2 priming beats. Required: output order preserved across two pointer wraps and count constant at 2.
- Flush with simultaneous push and pop at count 3. Required: count 0 next cycle, o_have 0, o_want 1, and the pushed beat absent from the output.
- Async reset asserted mid-stream at count 2. Required: o_have, o_want, o_count and o_almost_full are 0 immediately without a clock. After release, o_want is 1 after the first edge.
- With PIPE_ELASTIC_BYPASS_EN, empty, i_have=i_want=1, i_in=0xA5. Required: o_have=1 and o_out=0xA5 in the same cycle, and o_count stays 0.
